a2o_mem_arb: RTL

- Arbitrates the 128-bit direct-attach memory port between two requesters: the A2O core memory port and a 32-bit Wishbone slave port (debug/DMA/loader masters).
- Sits between the core wrapper and the memory model or SRAM macro.
- Serialises one access at a time, supports a fixed-latency memory read, and uses round-robin on contention.

---
 rtl/a2o_mem_arb.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/a2o_mem_arb.sv
// Two-requester arbiter for the 128-bit direct-attach memory port: A2O core vs. a
// 32-bit Wishbone slave. One access in flight, fixed-latency reads, round-robin on ties.
module a2o_mem_arb #(
    parameter int         MEM_RD_LAT = 1,
    parameter logic [3:0] WB_WIN     = 4'h0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           c_req,
    input  logic [0:31]    c_adr,
    input  logic           c_we,
    input  logic [0:15]    c_be,
    input  logic [0:127]   c_wdat,
    output logic           c_ack,
    output logic [0:127]   c_rdat,
    input  logic           wb_cyc,
    input  logic           wb_stb,
    input  logic           wb_we,
    input  logic [31:0]    wb_adr,
    input  logic [3:0]     wb_sel,
    input  logic [31:0]    wb_datw,
    output logic           wb_ack,
    output logic [31:0]    wb_datr,
    output logic [0:31]    mem_adr,
    output logic           mem_rd_val,
    input  logic [0:127]   mem_dat,
    output logic           mem_wr_val,
    output logic [0:15]    mem_wr_be,
    output logic [0:127]   mem_wr_dat
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, ACK = 2'd2} state_t;

    localparam logic [1:0] LAT_M1 = 2'(MEM_RD_LAT - 1);

    state_t         r_state, w_state_nx;
    logic [1:0]     r_cnt, w_cnt_nx;
    logic           r_gnt_wb, w_gnt_wb_nx;
    logic           r_last_wb, w_last_wb_nx;
    logic           r_oow, w_oow_nx;
    logic           r_abort, w_abort_nx;
    logic [1:0]     r_lane, w_lane_nx;
    logic           r_we, w_we_nx;
    logic           r_c_ack, w_c_ack_nx;
    logic           r_wb_ack, w_wb_ack_nx;
    logic [0:127]   r_c_rdat, w_c_rdat_nx;
    logic [31:0]    r_wb_datr, w_wb_datr_nx;
    logic [0:31]    r_mem_adr, w_mem_adr_nx;
    logic           r_mem_rd, w_mem_rd_nx;
    logic           r_mem_wr, w_mem_wr_nx;
    logic [0:15]    r_mem_be, w_mem_be_nx;
    logic [0:127]   r_mem_dat, w_mem_dat_nx;

    logic           w_c_pend, w_wb_pend, w_pick_wb, w_wb_oow;
    logic [0:15]    w_wb_be;
    logic           w_unused;

    assign w_c_pend  = c_req;
    assign w_wb_pend = wb_cyc & wb_stb;
    // Tie goes to whoever did not win last time.
    assign w_pick_wb = w_wb_pend & (~w_c_pend | ~r_last_wb);
    assign w_wb_oow  = (wb_adr[31:28] != WB_WIN);
    // Lane 0 enables sit in be[0:3]; wb_sel[3] maps to the lowest be index of the lane.
    assign w_wb_be   = 16'({wb_sel, 12'h000} >> {wb_adr[3:2], 2'b00});
    assign w_unused  = &{1'b0, c_adr[28:31], wb_adr[1:0]};

    // Next-state and next-output decode.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_gnt_wb_nx  = r_gnt_wb;
        w_last_wb_nx = r_last_wb;
        w_oow_nx     = r_oow;
        w_abort_nx   = r_abort;
        w_lane_nx    = r_lane;
        w_we_nx      = r_we;
        w_c_ack_nx   = 1'b0;
        w_wb_ack_nx  = 1'b0;
        w_c_rdat_nx  = r_c_rdat;
        w_wb_datr_nx = r_wb_datr;
        w_mem_adr_nx = 32'h0000_0000;
        w_mem_rd_nx  = 1'b0;
        w_mem_wr_nx  = 1'b0;
        w_mem_be_nx  = 16'h0000;
        w_mem_dat_nx = 128'h0;
        case (r_state)
            IDLE: begin
                // While an ack is on the wire the finished requester still holds its request.
                if (!(r_c_ack | r_wb_ack) && (w_c_pend | w_wb_pend)) begin
                    w_gnt_wb_nx  = w_pick_wb;
                    w_last_wb_nx = w_pick_wb;
                    w_abort_nx   = 1'b0;
                    w_cnt_nx     = LAT_M1;
                    if (w_pick_wb) begin
                        w_oow_nx  = w_wb_oow;
                        w_lane_nx = wb_adr[3:2];
                        w_we_nx   = wb_we;
                        if (!w_wb_oow) begin
                            w_mem_adr_nx = {wb_adr[31:4], 4'h0};
                            w_mem_wr_nx  = wb_we;
                            w_mem_rd_nx  = ~wb_we;
                            if (wb_we) begin
                                w_mem_be_nx  = w_wb_be;
                                w_mem_dat_nx = {4{wb_datw}};
                            end else begin
                                w_mem_be_nx  = 16'h0000;
                            end
                        end else begin
                            w_mem_adr_nx = 32'h0000_0000;
                        end
                        w_state_nx = (wb_we | w_wb_oow) ? ACK : RD_WAIT;
                    end else begin
                        w_oow_nx     = 1'b0;
                        w_lane_nx    = 2'b00;
                        w_we_nx      = c_we;
                        w_mem_adr_nx = {c_adr[0:27], 4'h0};
                        w_mem_wr_nx  = c_we;
                        w_mem_rd_nx  = ~c_we;
                        if (c_we) begin
                            w_mem_be_nx  = c_be;
                            w_mem_dat_nx = c_wdat;
                        end else begin
                            w_mem_be_nx  = 16'h0000;
                        end
                        w_state_nx = c_we ? ACK : RD_WAIT;
                    end
                end else begin
                    w_state_nx = IDLE;
                end
            end
            RD_WAIT: begin
                if (r_gnt_wb && !wb_cyc) begin
                    w_abort_nx = 1'b1;
                end else begin
                    w_abort_nx = r_abort;
                end
                if (r_cnt == 2'd0) begin
                    w_state_nx = ACK;
                end else begin
                    w_cnt_nx = r_cnt - 2'd1;
                end
            end
            ACK: begin
                w_state_nx = IDLE;
                if (r_gnt_wb) begin
                    if (wb_cyc && !r_abort) begin
                        w_wb_ack_nx = 1'b1;
                        if (r_oow) begin
                            w_wb_datr_nx = 32'h0000_0000;
                        end else if (!r_we) begin
                            w_wb_datr_nx = mem_dat[{r_lane, 5'b00000} +: 32];
                        end else begin
                            w_wb_datr_nx = r_wb_datr;
                        end
                    end else begin
                        w_wb_ack_nx = 1'b0;
                    end
                end else begin
                    w_c_ack_nx = 1'b1;
                    if (!r_we) begin
                        w_c_rdat_nx = mem_dat;
                    end else begin
                        w_c_rdat_nx = r_c_rdat;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything and favours the core next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 2'd0;
            r_gnt_wb  <= 1'b0;
            r_last_wb <= 1'b1;
            r_oow     <= 1'b0;
            r_abort   <= 1'b0;
            r_lane    <= 2'b00;
            r_we      <= 1'b0;
            r_c_ack   <= 1'b0;
            r_wb_ack  <= 1'b0;
            r_c_rdat  <= 128'h0;
            r_wb_datr <= 32'h0000_0000;
            r_mem_adr <= 32'h0000_0000;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_mem_be  <= 16'h0000;
            r_mem_dat <= 128'h0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_gnt_wb  <= w_gnt_wb_nx;
            r_last_wb <= w_last_wb_nx;
            r_oow     <= w_oow_nx;
            r_abort   <= w_abort_nx;
            r_lane    <= w_lane_nx;
            r_we      <= w_we_nx;
            r_c_ack   <= w_c_ack_nx;
            r_wb_ack  <= w_wb_ack_nx;
            r_c_rdat  <= w_c_rdat_nx;
            r_wb_datr <= w_wb_datr_nx;
            r_mem_adr <= w_mem_adr_nx;
            r_mem_rd  <= w_mem_rd_nx;
            r_mem_wr  <= w_mem_wr_nx;
            r_mem_be  <= w_mem_be_nx;
            r_mem_dat <= w_mem_dat_nx;
        end
    end

    assign c_ack      = r_c_ack;
    assign c_rdat     = r_c_rdat;
    assign wb_ack     = r_wb_ack;
    assign wb_datr    = r_wb_datr;
    assign mem_adr    = r_mem_adr;
    assign mem_rd_val = r_mem_rd;
    assign mem_wr_val = r_mem_wr;
    assign mem_wr_be  = r_mem_be;
    assign mem_wr_dat = r_mem_dat;

endmodule
